// File: rtl/hwpe_axi_stream_packer.sv
// Packs PACK_FACTOR narrow valid/grant beats into one wide word.
// A last_in beat closes the word early; unused lanes are zero with strb low.
module hwpe_axi_stream_packer #(
    parameter int DATA_WIDTH  = 32,
    parameter int PACK_FACTOR = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             data_in,
    input  logic                              valid_in,
    input  logic                              last_in,
    output logic                              grant_out,
    output logic [PACK_FACTOR*DATA_WIDTH-1:0] data_out,
    output logic [PACK_FACTOR-1:0]            strb_out,
    output logic                              last_out,
    output logic                              valid_out,
    input  logic                              grant_in
);

    localparam int CNT_WIDTH = $clog2(PACK_FACTOR);
    localparam int WW        = PACK_FACTOR * DATA_WIDTH;

    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]          acc_q, acc_d;
    logic [PACK_FACTOR-1:0] acc_strb_q, acc_strb_d;
    logic [WW-1:0]          out_data_q, out_data_d;
    logic [PACK_FACTOR-1:0] out_strb_q, out_strb_d;
    logic                   out_last_q, out_last_d;
    logic                   valid_q, valid_d;

    logic [WW-1:0]          merged_data;
    logic [PACK_FACTOR-1:0] merged_strb;
    logic                   accept;
    logic                   complete;
    logic                   consume;

    assign grant_out = !valid_q || grant_in;
    assign valid_out = valid_q;
    assign data_out  = out_data_q;
    assign strb_out  = out_strb_q;
    assign last_out  = out_last_q;

    assign accept   = valid_in && grant_out;
    assign complete = accept &&
                      (last_in || cnt_q == CNT_WIDTH'(PACK_FACTOR - 1));
    assign consume  = valid_q && grant_in;

    // Current accumulator with the incoming beat dropped into lane cnt.
    always_comb begin
        merged_data = acc_q;
        merged_strb = acc_strb_q;
        for (int i = 0; i < PACK_FACTOR; i++) begin
            if (cnt_q == CNT_WIDTH'(i)) begin
                merged_data[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
                merged_strb[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        acc_strb_d = acc_strb_q;
        out_data_d = out_data_q;
        out_strb_d = out_strb_q;
        out_last_d = out_last_q;
        valid_d    = valid_q;

        if (consume) begin
            valid_d = 1'b0;
        end

        if (complete) begin
            out_data_d = merged_data;
            out_strb_d = merged_strb;
            out_last_d = last_in;
            valid_d    = 1'b1;
            acc_d      = '0;
            acc_strb_d = '0;
            cnt_d      = '0;
        end else if (accept) begin
            acc_d      = merged_data;
            acc_strb_d = merged_strb;
            cnt_d      = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            acc_strb_q <= '0;
            out_data_q <= '0;
            out_strb_q <= '0;
            out_last_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            acc_strb_q <= acc_strb_d;
            out_data_q <= out_data_d;
            out_strb_q <= out_strb_d;
            out_last_q <= out_last_d;
            valid_q    <= valid_d;
        end
    end

endmodule
